// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the LEGv8 multicycle sequencer: state encodings,
// opcode match patterns, ALUOp constants and fault codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_WB_R   = 4'd4,
        ST_ADDR   = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_WB_LD  = 4'd7,
        ST_MEM_WR = 4'd8,
        ST_BRANCH = 4'd9,
        ST_HALT   = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Opcode patterns as mask/value pairs; a mask bit of 0 is a don't-care.
    localparam logic [10:0] R_MASK    = 11'b10011110111;
    localparam logic [10:0] R_BITS    = 11'b10001010000;
    localparam logic [10:0] MEM_MASK  = 11'b11111111111;
    localparam logic [10:0] LDUR_BITS = 11'b11111000010;
    localparam logic [10:0] STUR_BITS = 11'b11111000000;
    localparam logic [10:0] CBZ_MASK  = 11'b11111111000;
    localparam logic [10:0] CBZ_BITS  = 11'b10110100000;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] mask,
                                      input logic [10:0] bits);
        return (op & mask) == bits;
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return s inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the sequencer and the memory.
interface multicycle_ctrl_if;

    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  i_or_d,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_opcode_class.sv
// Combinational opcode classifier; same patterns as the single-cycle decoder.
module multicycle_ctrl_opcode_class
    import multicycle_ctrl_pkg::*;
(
    input  logic [10:0] opcode,
    output logic        is_r,
    output logic        is_ld,
    output logic        is_st,
    output logic        is_cbz
);

    assign is_r   = op_match(opcode, R_MASK,   R_BITS);
    assign is_ld  = op_match(opcode, MEM_MASK, LDUR_BITS);
    assign is_st  = op_match(opcode, MEM_MASK, STUR_BITS);
    assign is_cbz = op_match(opcode, CBZ_MASK, CBZ_BITS);

endmodule

// File: rtl/multicycle_ctrl.sv
// LEGv8 multicycle sequencer: walks each instruction through its phases over a
// shared memory port, counts retired instructions and halts on faults.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [10:0]        opcode,
    input  logic               zero,
    multicycle_ctrl_if.master  mem,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               reg2loc,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [1:0]         alu_op,
    output logic               busy,
    output logic [1:0]         fault,
    output logic [CNT_W-1:0]   retired
);

    localparam int            TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] to_cnt;
    logic          to_expired;
    logic          retire;
    logic [1:0]    fault_set;
    logic          is_r;
    logic          is_ld;
    logic          is_st;
    logic          is_cbz;

    multicycle_ctrl_opcode_class u_class (
        .opcode (opcode),
        .is_r   (is_r),
        .is_ld  (is_ld),
        .is_st  (is_st),
        .is_cbz (is_cbz)
    );

    // A ready on the final allowed wait cycle still wins over the timeout.
    assign to_expired = !mem.mem_ready && (to_cnt == TO_LAST);
    assign busy       = (state != ST_IDLE) && (state != ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            retired <= '0;
            fault   <= FAULT_NONE;
        end else begin
            if (state_next != state) begin
                to_cnt <= '0;
            end else if (is_mem_state(state)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (retire) begin
                retired <= retired + 1'b1;
            end
            if (fault_set != FAULT_NONE) begin
                fault <= fault_set;
            end
        end
    end

    // FETCH qualifies ir_write/pc_write with mem_ready because the IR can only
    // be loaded in the cycle the read data is actually present.
    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        fault_set   = FAULT_NONE;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.i_or_d  = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg2loc     = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_op      = ALUOP_ADD;

        unique case (state)
            ST_IDLE: begin
                if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (to_expired) begin
                    fault_set  = FAULT_TIMEOUT;
                    state_next = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (is_r) begin
                    state_next = ST_EXEC_R;
                end else if (is_ld || is_st) begin
                    state_next = ST_ADDR;
                end else if (is_cbz) begin
                    state_next = ST_BRANCH;
                end else begin
                    fault_set  = FAULT_ILLEGAL;
                    state_next = ST_HALT;
                end
            end
            ST_EXEC_R: begin
                alu_op     = ALUOP_FUNCT;
                state_next = ST_WB_R;
            end
            ST_WB_R: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = run ? ST_FETCH : ST_IDLE;
            end
            ST_ADDR: begin
                alu_src    = 1'b1;
                reg2loc    = is_st;
                state_next = is_st ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem.mem_req = 1'b1;
                mem.i_or_d  = 1'b1;
                if (mem.mem_ready) begin
                    state_next = ST_WB_LD;
                end else if (to_expired) begin
                    fault_set  = FAULT_TIMEOUT;
                    state_next = ST_HALT;
                end
            end
            ST_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = run ? ST_FETCH : ST_IDLE;
            end
            ST_MEM_WR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.i_or_d  = 1'b1;
                reg2loc     = 1'b1;
                if (mem.mem_ready) begin
                    retire     = 1'b1;
                    state_next = run ? ST_FETCH : ST_IDLE;
                end else if (to_expired) begin
                    fault_set  = FAULT_TIMEOUT;
                    state_next = ST_HALT;
                end
            end
            ST_BRANCH: begin
                reg2loc    = 1'b1;
                alu_op     = ALUOP_PASSB;
                pc_src     = 1'b1;
                pc_write   = zero;
                retire     = 1'b1;
                state_next = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model predicts the
// control vector of every cycle and a falling-edge process compares it.
module tb_multicycle_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    localparam int CL_R   = 0;
    localparam int CL_LD  = 1;
    localparam int CL_ST  = 2;
    localparam int CL_CBZ = 3;
    localparam int CL_ILL = 4;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    typedef struct packed {
        logic             memReq;
        logic             memWe;
        logic             iOrD;
        logic             irWrite;
        logic             pcWrite;
        logic             pcSrc;
        logic             reg2loc;
        logic             aluSrc;
        logic             memToReg;
        logic             regWrite;
        logic [1:0]       aluOp;
        logic             busy;
        logic [1:0]       fault;
        logic [CNT_W-1:0] retired;
    } vec_t;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             run    = 1'b0;
    logic             zero   = 1'b0;
    logic [10:0]      opcode = '0;
    logic             ir_write, pc_write, pc_src, reg2loc, alu_src, mem_to_reg, reg_write;
    logic [1:0]       alu_op;
    logic             busy;
    logic [1:0]       fault;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl_if mem();

    multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (mem),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg2loc    (reg2loc),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_op     (alu_op),
        .busy       (busy),
        .fault      (fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int         totalChecks = 0;
    int         badChecks   = 0;
    vec_t       expq[$];
    int         modelRetired = 0;
    logic [1:0] modelFault   = 2'b00;
    int         obsBusy, obsReq, obsReqData, obsRegWrite, obsMemToReg, obsTaken;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        totalChecks++;
        if (act !== want) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] op, input logic rdy, input logic z,
                                 input logic rn, input logic rs);
        @(posedge clk);
        #1;
        opcode        = op;
        mem.mem_ready = rdy;
        zero          = z;
        run           = rn;
        rst           = rs;
    endtask

    task automatic cyc(input vec_t e, input logic [10:0] op, input logic rdy, input logic z,
                       input logic rn, input logic rs);
        applyStimulus(op, rdy, z, rn, rs);
        expq.push_back(e);
    endtask

    function automatic vec_t busyVec();
        vec_t v;
        v         = '0;
        v.busy    = 1'b1;
        v.fault   = modelFault;
        v.retired = CNT_W'(modelRetired);
        return v;
    endfunction

    function automatic vec_t quietVec();
        vec_t v;
        v         = busyVec();
        v.busy    = 1'b0;
        return v;
    endfunction

    function automatic int classify(input logic [10:0] op);
        casez (op)
            11'b1??0101?000: return CL_R;
            11'b11111000010: return CL_LD;
            11'b11111000000: return CL_ST;
            11'b10110100???: return CL_CBZ;
            default:         return CL_ILL;
        endcase
    endfunction

    task automatic retire();
        modelRetired = (modelRetired + 1) % (1 << CNT_W);
    endtask

    task automatic resetCycle();
        applyStimulus('0, 1'b1, 1'b0, 1'b0, 1'b1);
        modelRetired = 0;
        modelFault   = 2'b00;
    endtask

    // IDLE and HALT look the same from outside: no strobes, busy low.
    task automatic quietCycle(input logic rn);
        cyc(quietVec(), '0, 1'b1, 1'b0, rn, 1'b0);
    endtask

    task automatic waitSettle();
        @(negedge clk);
        #1;
    endtask

    task automatic clearObs();
        obsBusy = 0; obsReq = 0; obsReqData = 0;
        obsRegWrite = 0; obsMemToReg = 0; obsTaken = 0;
    endtask

    // One instruction from fetch to retirement; fwait/mwait are the idle memory
    // cycles before mem_ready. killIn asserts rst on the final memory cycle.
    task automatic doInstr(input logic [10:0] op, input int fwait, input int mwait,
                           input logic z, input logic runAfter, input logic killIn);
        vec_t v;
        int   cls;
        for (int i = 0; i <= fwait; i++) begin
            v         = busyVec();
            v.memReq  = 1'b1;
            v.irWrite = (i == fwait);
            v.pcWrite = (i == fwait);
            cyc(v, op, i == fwait, z, runAfter, 1'b0);
        end
        cyc(busyVec(), op, 1'b1, z, runAfter, 1'b0);
        cls = classify(op);
        case (cls)
            CL_R: begin
                v = busyVec(); v.aluOp = 2'b10;
                cyc(v, op, 1'b1, z, runAfter, 1'b0);
                v = busyVec(); v.regWrite = 1'b1;
                cyc(v, op, 1'b1, z, runAfter, 1'b0);
                retire();
            end
            CL_LD, CL_ST: begin
                v = busyVec(); v.aluSrc = 1'b1; v.reg2loc = (cls == CL_ST);
                cyc(v, op, 1'b1, z, runAfter, 1'b0);
                for (int i = 0; i <= mwait; i++) begin
                    v = busyVec(); v.memReq = 1'b1; v.iOrD = 1'b1;
                    v.memWe = (cls == CL_ST); v.reg2loc = (cls == CL_ST);
                    cyc(v, op, i == mwait, z, runAfter, killIn && (i == mwait));
                end
                if (killIn) begin
                    modelRetired = 0;
                    modelFault   = 2'b00;
                end else if (cls == CL_ST) begin
                    retire();
                end else begin
                    v = busyVec(); v.regWrite = 1'b1; v.memToReg = 1'b1;
                    cyc(v, op, 1'b1, z, runAfter, 1'b0);
                    retire();
                end
            end
            CL_CBZ: begin
                v = busyVec(); v.reg2loc = 1'b1; v.aluOp = 2'b01;
                v.pcSrc = 1'b1; v.pcWrite = z;
                cyc(v, op, 1'b1, z, runAfter, 1'b0);
                retire();
            end
            default: modelFault = 2'b01;
        endcase
    endtask

    task automatic fetchTimeout();
        vec_t v;
        for (int i = 0; i < TIMEOUT; i++) begin
            v        = busyVec();
            v.memReq = 1'b1;
            cyc(v, OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        modelFault = 2'b10;
    endtask

    always @(negedge clk) begin : compare
        vec_t act;
        vec_t want;
        act = {mem.mem_req, mem.mem_we, mem.i_or_d, ir_write, pc_write, pc_src, reg2loc,
               alu_src, mem_to_reg, reg_write, alu_op, busy, fault, retired};
        obsBusy     += busy ? 1 : 0;
        obsReq      += mem.mem_req ? 1 : 0;
        obsReqData  += (mem.mem_req && mem.i_or_d) ? 1 : 0;
        obsRegWrite += reg_write ? 1 : 0;
        obsMemToReg += (reg_write && mem_to_reg) ? 1 : 0;
        obsTaken    += (pc_write && pc_src) ? 1 : 0;
        if (expq.size() > 0) begin
            want = expq.pop_front();
            checkOutput("cycle", 32'(act), 32'(want));
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mem.mem_ready = 1'b0;
        clearObs();
        resetCycle();
        resetCycle();
        quietCycle(1'b0);
        waitSettle();
        checkOutput("reset_retired", 32'(retired), 0);
        checkOutput("reset_fault", 32'(fault), 0);
        checkOutput("reset_busy", 32'(busy), 0);

        clearObs();
        quietCycle(1'b1);
        doInstr(OP_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        quietCycle(1'b0);
        waitSettle();
        checkOutput("add_busy_cycles", obsBusy, 4);
        checkOutput("add_reg_write_pulses", obsRegWrite, 1);
        checkOutput("add_retired", 32'(retired), 1);

        clearObs();
        quietCycle(1'b1);
        doInstr(OP_LDUR, 0, 3, 1'b0, 1'b0, 1'b0);
        quietCycle(1'b0);
        waitSettle();
        checkOutput("ldur_busy_cycles", obsBusy, 8);
        checkOutput("ldur_data_req_cycles", obsReqData, 4);
        checkOutput("ldur_mem_to_reg", obsMemToReg, 1);
        checkOutput("ldur_retired", 32'(retired), 2);

        clearObs();
        quietCycle(1'b1);
        doInstr(OP_CBZ, 0, 0, 1'b1, 1'b1, 1'b0);
        doInstr(OP_CBZ, 0, 0, 1'b0, 1'b0, 1'b0);
        quietCycle(1'b0);
        waitSettle();
        checkOutput("cbz_taken_count", obsTaken, 1);
        checkOutput("cbz_retired", 32'(retired), 4);

        quietCycle(1'b1);
        doInstr(OP_SUB, 2, 0, 1'b0, 1'b1, 1'b0);
        doInstr(OP_STUR, 0, 1, 1'b0, 1'b1, 1'b0);
        doInstr(OP_LDUR, TIMEOUT - 1, TIMEOUT - 1, 1'b0, 1'b1, 1'b0);
        doInstr(OP_ORR, 0, 0, 1'b1, 1'b0, 1'b0);
        quietCycle(1'b0);
        waitSettle();
        checkOutput("mix_retired", 32'(retired), 8);
        checkOutput("mix_fault", 32'(fault), 0);

        quietCycle(1'b1);
        doInstr(OP_BAD, 0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) quietCycle(i[0]);
        waitSettle();
        checkOutput("illegal_fault", 32'(fault), 1);
        checkOutput("illegal_busy", 32'(busy), 0);
        checkOutput("illegal_retired", 32'(retired), 8);

        resetCycle();
        quietCycle(1'b1);
        doInstr(OP_ADD, 0, 0, 1'b0, 1'b0, 1'b0);
        quietCycle(1'b0);
        waitSettle();
        clearObs();
        quietCycle(1'b1);
        fetchTimeout();
        for (int i = 0; i < 3; i++) quietCycle(1'b1);
        waitSettle();
        checkOutput("timeout_req_cycles", obsReq, 8);
        checkOutput("timeout_fault", 32'(fault), 2);
        checkOutput("timeout_retired", 32'(retired), 1);

        resetCycle();
        quietCycle(1'b1);
        doInstr(OP_ADD, 0, 0, 1'b0, 1'b1, 1'b0);
        doInstr(OP_STUR, 0, 2, 1'b0, 1'b1, 1'b1);
        quietCycle(1'b0);
        waitSettle();
        checkOutput("rst_mem_wr_retired", 32'(retired), 0);
        checkOutput("rst_mem_wr_req", 32'(mem.mem_req), 0);

        quietCycle(1'b1);
        for (int k = 0; k < 16; k++) doInstr(OP_CBZ, 0, 0, k[0], k != 15, 1'b0);
        quietCycle(1'b0);
        waitSettle();
        checkOutput("wrap_retired", 32'(retired), 0);
        checkOutput("wrap_pending", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
